// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial add/subtract, one 4-bit slice per clock, LSB first; ADDSUB_SEQ_SAT_EN enables saturation on overflow.
// Latency: done pulses NIBBLES+1 cycles after the accepting edge; start is ignored while busy.
module addsub_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   c_out,
    output logic                   v
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_op;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic [W-1:0]    r_result;
    logic            r_c_out;
    logic            r_v;
    logic            r_busy;
    logic            r_done;

    logic [3:0]      w_an;
    logic [3:0]      w_bx;
    logic [4:0]      w_sum;
    logic            w_c3;
    logic            w_last;

    // Subtraction is a + ~b + 1: the carry register is seeded with op on accept.
    assign w_an   = r_a[4*r_idx +: 4];
    assign w_bx   = r_b[4*r_idx +: 4] ^ {4{r_op}};
    assign w_sum  = {1'b0, w_an} + {1'b0, w_bx} + {4'b0000, r_carry};
    assign w_c3   = w_an[3] ^ w_bx[3] ^ w_sum[3];
    assign w_last = (r_idx == IW'(NIBBLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_c_out  <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_op     <= op;
                        r_idx    <= '0;
                        r_carry  <= op;
                        r_result <= '0;
                    end
                end
                S_RUN: begin
                    r_result[4*r_idx +: 4] <= w_sum[3:0];
                    r_carry                <= w_sum[4];
                    r_idx                  <= w_last ? '0 : r_idx + IW'(1);
                    if (w_last) begin
                        r_c_out <= w_sum[4] ^ r_op;
                        r_v     <= w_c3 ^ w_sum[4];
`ifdef ADDSUB_SEQ_SAT_EN
                        // Overflow direction follows the sign of a.
                        if (w_c3 ^ w_sum[4])
                            r_result <= r_a[W-1] ? {1'b1, {(W-1){1'b0}}}
                                                 : {1'b0, {(W-1){1'b1}}};
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign c_out  = r_c_out;
    assign v      = r_v;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl: stimulus pushes expected results, a negedge monitor checks them on done.
module tb_addsub_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        c_out;
    logic        v;

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        ov;
        longint      t;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_done = 1'b0;
    logic hold_vld  = 1'b0;
    logic [15:0] hold_res = '0;

`ifdef ADDSUB_SEQ_SAT_EN
    localparam logic [15:0] OVF_POS = 16'h7FFF;
    localparam logic [15:0] OVF_NEG = 16'h8000;
    localparam logic [15:0] OVF_NN  = 16'h8000;
`else
    localparam logic [15:0] OVF_POS = 16'h8000;
    localparam logic [15:0] OVF_NEG = 16'h7FFF;
    localparam logic [15:0] OVF_NN  = 16'h0000;
`endif

    addsub_seq_ctrl #(.NIBBLES(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .v      (v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse; otherwise checks result holds while idle.
    always @(negedge clk) begin
        exp_t e;
        if (reset) hold_vld = 1'b0;
        if (done === 1'b1) begin
            chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", {16'd0, result}, {16'd0, e.res});
                chk("c_out", {31'd0, c_out}, {31'd0, e.co});
                chk("v", {31'd0, v}, {31'd0, e.ov});
                chk("done_time", 32'($time), 32'(e.t));
                hold_vld = 1'b1;
                hold_res = e.res;
            end
        end else if (!busy && hold_vld && !reset) begin
            chk("result_hold", {16'd0, result}, {16'd0, hold_res});
        end
        prev_done = done;
    end

    // Called at a negedge while the DUT is idle; returns at the negedge before the next possible accept.
    task automatic issue(input logic o, input logic [15:0] aa, input logic [15:0] bb,
                         input logic [15:0] er, input logic eco, input logic ev);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        @(posedge clk);
        e.res = er; e.co = eco; e.ov = ev; e.t = longint'($time) + 45;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a     = 16'($urandom);
        b     = 16'($urandom);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        longint t0;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_c_out", {31'd0, c_out}, 32'd0);
        chk("rst_v", {31'd0, v}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b0, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 1'b0);
        issue(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0);
        issue(1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0);
        issue(1'b0, 16'h8000, 16'h8000, OVF_NN,   1'b1, 1'b1);
        issue(1'b1, 16'h8000, 16'h0001, OVF_NEG,  1'b0, 1'b1);
        issue(1'b0, 16'h7FFF, 16'h0001, OVF_POS,  1'b0, 1'b1);

        // Reset sampled at E2 of an in-flight operation: everything clears, no done.
        start = 1'b1; op = 1'b0; a = 16'hFFFF; b = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
        chk("midrun_rst_done", {31'd0, done}, 32'd0);
        chk("midrun_rst_result", {16'd0, result}, 32'd0);
        chk("midrun_rst_c_out", {31'd0, c_out}, 32'd0);
        chk("midrun_rst_v", {31'd0, v}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        issue(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);

        // Start held high with operands changing every cycle: accepts at E0 and E6 only.
        start = 1'b1; op = 1'b0; a = 16'h0100; b = 16'h0011;
        @(posedge clk);
        t0 = longint'($time);
        e.res = 16'h0111; e.co = 1'b0; e.ov = 1'b0; e.t = t0 + 45;
        sb.push_back(e);
        e.res = 16'h0777; e.co = 1'b0; e.ov = 1'b0; e.t = t0 + 105;
        sb.push_back(e);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            a = 16'((k + 1) * 16'h0100);
            b = 16'((k + 1) * 16'h0011);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/addsub_seq_ctrl.md
ADDSUB_SEQ_CTRL -- requirements
Module: addsub_seq_ctrl

Interface
REQ-001 SHALL have parameter: NIBBLES, 4, number of 4-bit slices; data width W = 4*NIBBLES.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: op  input  1  0 = add (a+b), 1 = subtract (a-b), captured with operands.
REQ-006 SHALL have port: a  input  W  operand A, captured on accepting edge.
REQ-007 SHALL have port: b  input  W  operand B, captured on accepting edge.
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: result  output  W  sum/difference, held until next accept or reset.
REQ-011 SHALL have port: c_out  output  1  final carry for add, borrow (carry XOR op) for subtract.
REQ-012 SHALL have port: v  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN, DONE; encoding free, all outputs registered.
REQ-014 SHALL, in IDLE with start=1 (accepting edge E0), capture a, b, op, clear result, set nibble index to 0, set carry register to op, enter RUN.
REQ-015 SHALL, in RUN, process exactly one 4-bit slice per clock, LSB first: slice i = a[4i+3:4i] + (b[4i+3:4i] XOR {4{op}}) + carry register.
REQ-016 SHALL write slice i into result[4i+3:4i] at edge E(i+1) and load the slice carry-out into the carry register.
REQ-017 SHALL, at the edge processing slice NIBBLES-1, update c_out and v from that slice's carries and enter DONE.
REQ-018 SHALL hold done=1 for exactly the cycle between edges E(NIBBLES) and E(NIBBLES+1), then return to IDLE with done=0.
REQ-019 SHALL ignore start, a, b, op while busy=1; operand changes during RUN SHALL NOT affect result.
REQ-020 SHALL accept a new start in the first IDLE cycle; continuous start gives one accept every NIBBLES+2 cycles.
REQ-021 SHALL keep result, c_out, v stable from DONE until the next accepting edge.
REQ-022 SHALL drop intermediate partial results on reset; no partially written result SHALL be flagged with done.

Reset
REQ-023 SHALL, on reset=1 at a rising edge, in any state including mid-RUN, force IDLE, busy=0, done=0, result=0, c_out=0, v=0, index=0, carry=0.
REQ-024 SHALL give reset priority over start on the same edge.

Configuration
REQ-025 SHALL honor macro ADDSUB_SEQ_SAT_EN: defined -> when v=1 at completion, result clamps to 0x7FFF (W=16) if a[W-1]=0, else 0x8000; v and c_out still report the raw condition.
REQ-026 SHALL, without ADDSUB_SEQ_SAT_EN, return the wrapped two's-complement result unchanged.

Verification
REQ-027 SHALL cover: op=0, a=0x1234, b=0x0F0F -> result=0x2143, c_out=0, v=0, done exactly one cycle after edge E4.
REQ-028 SHALL cover: op=1, a=0x0005, b=0x0007 -> result=0xFFFE, c_out=1, v=0.
REQ-029 SHALL cover: op=0, a=0x7FFF, b=0x0001 -> v=1, c_out=0; result=0x8000 without macro, 0x7FFF with ADDSUB_SEQ_SAT_EN.
REQ-030 SHALL cover: op=1, a=0x8000, b=0x0001 -> v=1, c_out=0; result=0x7FFF without macro, 0x8000 with macro.
REQ-031 SHALL cover: op=0, a=0xFFFF, b=0x0001, reset at E2 -> next edge all outputs 0, no done; restart gives result=0x0000, c_out=1, v=0.
REQ-032 SHALL cover: start held high, a/b toggled every cycle -> accepts at E0 and E6 only; results match operands captured at those edges.
